// File: rtl/bus_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_rr_if
//  Description : Request/grant bundle between the bus masters and the
//                N-master arbiter. The master side drives requests; the
//                slave side (the arbiter) returns grants and the mux select.
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_arbiter_rr_if #(
    parameter int N_MASTERS = 4,
    parameter int ID_W      = $clog2(N_MASTERS)
);
    logic [N_MASTERS-1:0] m_req;
    logic [N_MASTERS-1:0] m_grant;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 preempt;

    modport master (
        output m_req,
        input  m_grant,
        input  grant_valid,
        input  grant_id,
        input  preempt
    );

    modport slave (
        input  m_req,
        output m_grant,
        output grant_valid,
        output grant_id,
        output preempt
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_rr
//  Description : N-master bus arbiter with registered one-hot grant,
//                round-robin or fixed-priority selection, grant hold,
//                bounded burst with pre-emption and a one-cycle turnaround
//                between owners.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter_rr #(
    parameter int N_MASTERS = 4,
    parameter int MODE      = 0,
    parameter int MAX_HOLD  = 16,
    parameter int ID_W      = $clog2(N_MASTERS)
) (
    input  logic              clk,
    input  logic              reset,
    bus_arbiter_rr_if.slave   bus
);

    localparam logic [7:0] c_HOLD_LIMIT = 8'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_TURN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_MASTERS-1:0] r_grant;
    logic [N_MASTERS-1:0] w_grant_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic [ID_W-1:0]      r_id;
    logic [ID_W-1:0]      w_id_nxt;
    logic [ID_W-1:0]      r_last;
    logic [ID_W-1:0]      w_last_nxt;
    logic [7:0]           r_hold;
    logic [7:0]           w_hold_nxt;
    logic                 r_preempt;
    logic                 w_preempt_nxt;

    logic [ID_W-1:0]      w_winner;
    logic [N_MASTERS-1:0] w_onehot;
    logic                 w_compete;
    int                   w_idx;

    // Winner selection: rotate from the slot after the last owner, or lowest index.
    always_comb begin
        w_winner = '0;
        w_idx    = 0;
        if (MODE == 1) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (bus.m_req[i]) w_winner = ID_W'(i);
            end
        end else begin
            // Scanning the distance backwards lets the nearest requester win last.
            for (int k = N_MASTERS; k >= 1; k--) begin
                w_idx = (int'(r_last) + k) % N_MASTERS;
                if (bus.m_req[w_idx]) w_winner = ID_W'(w_idx);
            end
        end
        w_onehot           = '0;
        w_onehot[w_winner] = 1'b1;
    end

    // Next-state and next-output logic for the IDLE/BUSY/TURN sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_id_nxt      = r_id;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold;
        w_preempt_nxt = 1'b0;
        // Any requester other than the current owner counts as a competitor.
        w_compete     = |(bus.m_req & ~r_grant);

        case (r_state)
            S_IDLE, S_TURN: begin
                if (|bus.m_req) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = w_onehot;
                    w_id_nxt    = w_winner;
                    w_last_nxt  = w_winner;
                    w_hold_nxt  = 8'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_hold_nxt  = 8'd0;
                end
            end
            S_BUSY: begin
                if (!(|(bus.m_req & r_grant))) begin
                    w_state_nxt = S_TURN;
                    w_grant_nxt = '0;
                    w_hold_nxt  = 8'd0;
                end else if ((MAX_HOLD != 0) && (r_hold == c_HOLD_LIMIT) && w_compete) begin
                    w_state_nxt   = S_TURN;
                    w_grant_nxt   = '0;
                    w_hold_nxt    = 8'd0;
                    w_preempt_nxt = 1'b1;
                end else if ((MAX_HOLD != 0) && (r_hold != c_HOLD_LIMIT)) begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_hold_nxt  = 8'd0;
            end
        endcase

        w_valid_nxt = |w_grant_nxt;
    end

    // State and output registers; reset clears the grant without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_last    <= ID_W'(N_MASTERS - 1);
            r_hold    <= 8'd0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_valid   <= w_valid_nxt;
            r_id      <= w_id_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    assign bus.m_grant     = r_grant;
    assign bus.grant_valid = r_valid;
    assign bus.grant_id    = r_id;
    assign bus.preempt     = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter_rr
//  Description : Self-checking bench for bus_arbiter_rr. Three arbiters
//                (round-robin, fixed priority, no pre-emption) share one
//                request vector and are compared every cycle against an
//                owner-tracking reference model, plus directed scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_rr;

    logic       clk;
    logic       reset;
    logic [3:0] req;

    int n_checks;
    int n_fail;

    // Model state per configuration: 0 = RR/hold 4, 1 = FP/hold 4, 2 = RR/no pre-emption
    int cfg_mode [3] = '{0, 1, 0};
    int cfg_hold [3] = '{4, 4, 0};
    int mo_owner [3];
    int mo_last  [3];
    int mo_held  [3];
    int mo_id    [3];
    bit mo_pre   [3];

    bus_arbiter_rr_if #(.N_MASTERS(4)) bus_rr ();
    bus_arbiter_rr_if #(.N_MASTERS(4)) bus_fp ();
    bus_arbiter_rr_if #(.N_MASTERS(4)) bus_nh ();

    assign bus_rr.m_req = req;
    assign bus_fp.m_req = req;
    assign bus_nh.m_req = req;

    bus_arbiter_rr #(.N_MASTERS(4), .MODE(0), .MAX_HOLD(4)) dut_rr (
        .clk(clk), .reset(reset), .bus(bus_rr)
    );
    bus_arbiter_rr #(.N_MASTERS(4), .MODE(1), .MAX_HOLD(4)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus_fp)
    );
    bus_arbiter_rr #(.N_MASTERS(4), .MODE(0), .MAX_HOLD(0)) dut_nh (
        .clk(clk), .reset(reset), .bus(bus_nh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input int c, input logic [3:0] r);
        if (cfg_mode[c] == 1) begin
            for (int i = 0; i < 4; i++) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (r[(mo_last[c] + k) % 4]) return (mo_last[c] + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            mo_owner[c] = -1;
            mo_last[c]  = 3;
            mo_held[c]  = 0;
            mo_id[c]    = 0;
            mo_pre[c]   = 1'b0;
        end
    endtask

    task automatic model_step();
        int w;
        for (int c = 0; c < 3; c++) begin
            mo_pre[c] = 1'b0;
            if (mo_owner[c] < 0) begin
                w = pick(c, req);
                if (w >= 0) begin
                    mo_owner[c] = w;
                    mo_last[c]  = w;
                    mo_id[c]    = w;
                    mo_held[c]  = 1;
                end
            end else if (!req[mo_owner[c]]) begin
                mo_owner[c] = -1;
            end else if (cfg_hold[c] != 0 && mo_held[c] >= cfg_hold[c] &&
                         (req & ~(4'b0001 << mo_owner[c])) != 4'b0000) begin
                mo_owner[c] = -1;
                mo_pre[c]   = 1'b1;
            end else begin
                mo_held[c]++;
            end
        end
    endtask

    task automatic check_dut(input int c, input logic [3:0] g, input logic v,
                             input logic [1:0] id, input logic p);
        logic [3:0] exp_g;
        exp_g = (mo_owner[c] >= 0) ? (4'b0001 << mo_owner[c]) : 4'b0000;
        check_eq($sformatf("c%0d_grant", c), 32'(g), 32'(exp_g));
        check_eq($sformatf("c%0d_valid", c), 32'(v), 32'(mo_owner[c] >= 0));
        check_eq($sformatf("c%0d_id", c), 32'(id), 32'(mo_id[c]));
        check_eq($sformatf("c%0d_preempt", c), 32'(p), 32'(mo_pre[c]));
        check_eq($sformatf("c%0d_onehot0", c), 32'($onehot0(g)), 32'd1);
        check_eq($sformatf("c%0d_valid_or", c), 32'(v), 32'(|g));
    endtask

    task automatic check_all();
        check_dut(0, bus_rr.m_grant, bus_rr.grant_valid, bus_rr.grant_id, bus_rr.preempt);
        check_dut(1, bus_fp.m_grant, bus_fp.grant_valid, bus_fp.grant_id, bus_fp.preempt);
        check_dut(2, bus_nh.m_grant, bus_nh.grant_valid, bus_nh.grant_id, bus_nh.preempt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        req      = 4'b0000;
        reset    = 1'b1;
        model_reset();
        tick();
        tick();
        check_eq("rst_grant", 32'(bus_rr.m_grant), 32'h0);
        check_eq("rst_valid", 32'(bus_rr.grant_valid), 32'h0);
        check_eq("rst_id", 32'(bus_rr.grant_id), 32'h0);
        reset = 1'b0;

        // Round-robin rotation with everyone requesting
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                check_eq("rot_grant", 32'(bus_rr.m_grant), 32'(4'b0001 << (k % 4)));
                check_eq("rot_preempt", 32'(bus_rr.preempt), 32'h0);
            end
            tick();
            check_eq("rot_turn", 32'(bus_rr.m_grant), 32'h0);
            check_eq("rot_turn_preempt", 32'(bus_rr.preempt), 32'h1);
        end
        tick();
        check_eq("rot_wrap", 32'(bus_rr.m_grant), 32'b0010);

        // Asynchronous reset in the middle of a grant
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_grant", 32'(bus_rr.m_grant), 32'h0);
        check_eq("arst_valid", 32'(bus_rr.grant_valid), 32'h0);
        check_eq("arst_id", 32'(bus_rr.grant_id), 32'h0);
        model_reset();
        req = 4'b0100;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_rst_grant", 32'(bus_rr.m_grant), 32'b0100);

        // Voluntary release by master 0
        req = 4'b0000;
        do_reset();
        req = 4'b0011;
        tick();
        check_eq("vol_g0a", 32'(bus_rr.m_grant), 32'b0001);
        tick();
        check_eq("vol_g0b", 32'(bus_rr.m_grant), 32'b0001);
        req = 4'b0010;
        tick();
        check_eq("vol_turn", 32'(bus_rr.m_grant), 32'h0);
        check_eq("vol_preempt", 32'(bus_rr.preempt), 32'h0);
        tick();
        check_eq("vol_g1", 32'(bus_rr.m_grant), 32'b0010);

        // Sole requester keeps the bus
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 50; i++) begin
            tick();
            check_eq("sole_grant", 32'(bus_rr.m_grant), 32'b0100);
            check_eq("sole_preempt", 32'(bus_rr.preempt), 32'h0);
        end

        // Fixed priority starves master 2
        req = 4'b0000;
        do_reset();
        req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("fp_grant", 32'(bus_fp.m_grant), 32'b0010);
        end
        tick();
        check_eq("fp_turn", 32'(bus_fp.m_grant), 32'h0);
        check_eq("fp_preempt", 32'(bus_fp.preempt), 32'h1);
        tick();
        check_eq("fp_regrant", 32'(bus_fp.m_grant), 32'b0010);

        // Pre-emption disabled: owner holds until it lets go
        req = 4'b0000;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("nh_hold", 32'(bus_nh.m_grant), 32'b0001);
        end
        req = 4'b1110;
        tick();
        check_eq("nh_turn", 32'(bus_nh.m_grant), 32'h0);
        check_eq("nh_preempt", 32'(bus_nh.preempt), 32'h0);
        tick();
        check_eq("nh_next", 32'(bus_nh.m_grant), 32'b0010);

        // Random traffic with occasional asynchronous reset
        req = 4'b0000;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #1;
                check_eq("rnd_arst_rr", 32'(bus_rr.m_grant), 32'h0);
                check_eq("rnd_arst_fp", 32'(bus_fp.m_grant), 32'h0);
                check_eq("rnd_arst_nh", 32'(bus_nh.m_grant), 32'h0);
                model_reset();
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
